tia_color_lum_regs: RTL and testbench

Colour/luminance register block of the TIA video path. It holds the four CPU-written colour registers (background, playfield/ball, player 0/missile 0, player 1/missile 1). Each pixel clock it selects one register from the object-enable inputs and the priority and score controls, and drives the 3-bit luminance and 4-bit hue to the video output stage. It sits between the object serialisers/playfield logic and the composite output encoder.

---
 rtl/tia_color_lum_regs_pkg.sv | 55 +++++
 rtl/tia_color_lum_regs_reg.sv | 42 ++++
 rtl/tia_color_lum_regs.sv | 107 ++++++++++
 tb/tb_tia_color_lum_regs.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/tia_color_lum_regs_pkg.sv
// Shared definitions for the TIA colour/luminance register block.
// Contents: colour register type (bits numbered after CPU data bits D7..D1),
// register index constants, luminance/hue field positions and the
// object-priority select function used by the top-level mux.
package tia_color_lum_regs_pkg;

  // Colour value as written from the CPU bus; index n holds data bit Dn.
  typedef logic [7:1] color_t;

  // Register indices used by the output mux.
  localparam logic [1:0] REG_BK = 2'd0;
  localparam logic [1:0] REG_PF = 2'd1;
  localparam logic [1:0] REG_P1 = 2'd2;
  localparam logic [1:0] REG_P0 = 2'd3;

  // Field positions inside color_t.
  localparam int unsigned LUM_LSB = 1;
  localparam int unsigned LUM_MSB = 3;
  localparam int unsigned HUE_LSB = 4;
  localparam int unsigned HUE_MSB = 7;

  // Chooses which colour register paints the current pixel.
  // Score mode only recolours playfield pixels, keeps their priority slot,
  // and has no effect while playfield priority is active (pfp_bar = 0).
  function automatic logic [1:0] sel_index(
    input logic p0,
    input logic m0,
    input logic p1,
    input logic m1,
    input logic pf,
    input logic bl,
    input logic cntd,
    input logic score_bar,
    input logic pfp_bar
  );
    logic [1:0] idx;
    if (!pfp_bar) begin
      if (pf | bl)      idx = REG_PF;
      else if (p0 | m0) idx = REG_P0;
      else if (p1 | m1) idx = REG_P1;
      else              idx = REG_BK;
    end else begin
      if (p0 | m0)      idx = REG_P0;
      else if (p1 | m1) idx = REG_P1;
      else if (pf) begin
        if (!score_bar) idx = cntd ? REG_P1 : REG_P0;
        else            idx = REG_PF;
      end
      else if (bl)      idx = REG_PF;
      else              idx = REG_BK;
    end
    return idx;
  endfunction

endpackage

// File: rtl/tia_color_lum_regs_reg.sv
// tia_color_reg: one 7-bit colour register loaded from the CPU bus by a strobe.
// Ports:
//   clkp      - pixel clock
//   reset_bar - asynchronous active-low reset, clears the register
//   ld_i      - write strobe, loads d_i on the rising clock edge
//   d_i       - bus data {D7..D1}
//   q_o       - stored colour
module tia_color_reg
  import tia_color_lum_regs_pkg::*;
(
  input  logic   clkp,
  input  logic   reset_bar,
  input  logic   ld_i,
  input  color_t d_i,
  output color_t q_o
);

  color_t val_q;
  color_t val_d;

  // Next-state: load on strobe, otherwise hold.
  always_comb begin
    val_d = val_q;
    if (ld_i) begin
      val_d = d_i;
    end else begin
      val_d = val_q;
    end
  end

  // Colour storage register.
  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar) begin
      val_q <= 7'd0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/tia_color_lum_regs.sv
// tia_color_lum_regs: TIA colour/luminance register block.
// Holds COLUBK, COLUPF, COLUP1, COLUP0 and, every pixel clock, registers the
// colour of the highest-priority visible object (or black during blank).
// Ports:
//   clkp, reset_bar               - pixel clock, async active-low reset
//   p0, m0, p1, m1, pf, bl        - object pixel enables
//   blank                         - force black
//   cntd                          - screen half (0 left, 1 right) for score mode
//   score_bar, pfp_bar            - score mode / playfield priority (active low)
//   d1..d7                        - CPU data bus bits
//   bkci, pfci, p1ci, p0ci        - register write strobes
//   blk_bar                       - registered inverse of blank
//   l0..l2, c0..c3                - registered luminance and hue bits
module tia_color_lum_regs
  import tia_color_lum_regs_pkg::*;
(
  input  logic clkp,
  input  logic reset_bar,
  input  logic p0,
  input  logic m0,
  input  logic p1,
  input  logic m1,
  input  logic pf,
  input  logic bl,
  input  logic blank,
  input  logic cntd,
  input  logic score_bar,
  input  logic pfp_bar,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  input  logic bkci,
  input  logic pfci,
  input  logic p1ci,
  input  logic p0ci,
  output logic blk_bar,
  output logic l0,
  output logic l1,
  output logic l2,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3
);

  color_t     bus_s;
  color_t     bk_s;
  color_t     pf_s;
  color_t     p1_s;
  color_t     p0_s;
  logic [1:0] idx_s;
  color_t     col_s;
  color_t     out_d;
  color_t     out_q;
  logic       blk_d;
  logic       blk_q;

  assign bus_s = {d7, d6, d5, d4, d3, d2, d1};

  tia_color_reg u_bk (.clkp(clkp), .reset_bar(reset_bar), .ld_i(bkci), .d_i(bus_s), .q_o(bk_s));
  tia_color_reg u_pf (.clkp(clkp), .reset_bar(reset_bar), .ld_i(pfci), .d_i(bus_s), .q_o(pf_s));
  tia_color_reg u_p1 (.clkp(clkp), .reset_bar(reset_bar), .ld_i(p1ci), .d_i(bus_s), .q_o(p1_s));
  tia_color_reg u_p0 (.clkp(clkp), .reset_bar(reset_bar), .ld_i(p0ci), .d_i(bus_s), .q_o(p0_s));

  // Priority/score mux and blanking; register outputs see pre-write values.
  always_comb begin
    idx_s = sel_index(p0, m0, p1, m1, pf, bl, cntd, score_bar, pfp_bar);
    case (idx_s)
      REG_BK:  col_s = bk_s;
      REG_PF:  col_s = pf_s;
      REG_P1:  col_s = p1_s;
      REG_P0:  col_s = p0_s;
      default: col_s = bk_s;
    endcase
    if (blank) begin
      out_d = 7'd0;
    end else begin
      out_d = col_s;
    end
    blk_d = ~blank;
  end

  // Output register: one pixel of latency from the sampled selects.
  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar) begin
      out_q <= 7'd0;
      blk_q <= 1'b0;
    end else begin
      out_q <= out_d;
      blk_q <= blk_d;
    end
  end

  assign blk_bar = blk_q;
  assign l0 = out_q[LUM_LSB];
  assign l1 = out_q[LUM_LSB + 1];
  assign l2 = out_q[LUM_MSB];
  assign c0 = out_q[HUE_LSB];
  assign c1 = out_q[HUE_LSB + 1];
  assign c2 = out_q[HUE_LSB + 2];
  assign c3 = out_q[HUE_MSB];

endmodule

// File: tb/tb_tia_color_lum_regs.sv
// Directed testbench for tia_color_lum_regs.
module tb_tia_color_lum_regs;

  logic clkp = 1'b0;
  logic reset_bar;
  logic p0, m0, p1, m1, pf, bl;
  logic blank, cntd, score_bar, pfp_bar;
  logic d1, d2, d3, d4, d5, d6, d7;
  logic bkci, pfci, p1ci, p0ci;
  logic blk_bar, l0, l1, l2, c0, c1, c2, c3;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] V_BK = 7'b1110000;
  localparam logic [6:0] V_PF = 7'b1111111;
  localparam logic [6:0] V_P1 = 7'b0101010;
  localparam logic [6:0] V_P0 = 7'b1010101;
  localparam logic [6:0] V_BK2 = 7'b0011001;

  always #5 clkp = ~clkp;

  tia_color_lum_regs dut (
    .clkp(clkp), .reset_bar(reset_bar),
    .p0(p0), .m0(m0), .p1(p1), .m1(m1), .pf(pf), .bl(bl),
    .blank(blank), .cntd(cntd), .score_bar(score_bar), .pfp_bar(pfp_bar),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .bkci(bkci), .pfci(pfci), .p1ci(p1ci), .p0ci(p0ci),
    .blk_bar(blk_bar), .l0(l0), .l1(l1), .l2(l2),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3)
  );

  task automatic check(input string tag, input logic [6:0] exp_col, input logic exp_blk);
    logic [6:0] obs;
    obs = {c3, c2, c1, c0, l2, l1, l0};
    checks++;
    assert (obs === exp_col && blk_bar === exp_blk) else begin
      errors++;
      $error("FAIL %s: observed col=%b blk_bar=%b expected col=%b blk_bar=%b",
             tag, obs, blk_bar, exp_col, exp_blk);
    end
  endtask

  // Enables ordered {p0,m0,p1,m1,pf,bl}.
  task automatic set_en(input logic [5:0] e);
    {p0, m0, p1, m1, pf, bl} = e;
  endtask

  task automatic set_bus(input logic [6:0] v);
    {d7, d6, d5, d4, d3, d2, d1} = v;
  endtask

  task automatic tick();
    @(posedge clkp);
    #1;
  endtask

  task automatic step(input logic [5:0] e, input string tag, input logic [6:0] exp_col);
    set_en(e);
    tick();
    check(tag, exp_col, 1'b1);
  endtask

  task automatic wr(input logic [3:0] strobes, input logic [6:0] v);
    set_bus(v);
    {bkci, pfci, p1ci, p0ci} = strobes;
    tick();
    {bkci, pfci, p1ci, p0ci} = 4'b0000;
  endtask

  initial begin
    reset_bar = 1'b0;
    set_en(6'b000000);
    blank = 1'b0; cntd = 1'b0; score_bar = 1'b1; pfp_bar = 1'b1;
    set_bus(7'd0);
    {bkci, pfci, p1ci, p0ci} = 4'b0000;
    #2;
    check("reset_state", 7'd0, 1'b0);
    #10;
    reset_bar = 1'b1;
    tick();
    check("after_reset_bk0", 7'd0, 1'b1);

    wr(4'b1000, V_BK);
    wr(4'b0100, V_PF);
    wr(4'b0010, V_P1);
    wr(4'b0001, V_P0);
    step(6'b000000, "background", V_BK);

    step(6'b100000, "single_p0", V_P0);
    step(6'b010000, "single_m0", V_P0);
    step(6'b001000, "single_p1", V_P1);
    step(6'b000100, "single_m1", V_P1);
    step(6'b000010, "single_pf", V_PF);
    step(6'b000001, "single_bl", V_PF);

    step(6'b111111, "norm_all", V_P0);
    step(6'b011111, "norm_drop_p0", V_P0);
    step(6'b001111, "norm_drop_m0", V_P1);
    step(6'b000111, "norm_drop_p1", V_P1);
    step(6'b000011, "norm_drop_m1", V_PF);
    step(6'b000001, "norm_drop_pf", V_PF);
    step(6'b000000, "norm_drop_bl", V_BK);

    pfp_bar = 1'b0;
    step(6'b111111, "prio_all", V_PF);
    step(6'b111110, "prio_drop_bl", V_PF);
    step(6'b111100, "prio_drop_pf", V_P0);
    step(6'b101100, "prio_drop_m0", V_P0);
    step(6'b001100, "prio_drop_p0", V_P1);
    step(6'b001000, "prio_drop_m1", V_P1);
    score_bar = 1'b0; cntd = 1'b0;
    step(6'b000010, "prio_ignores_score", V_PF);

    pfp_bar = 1'b1;
    step(6'b000010, "score_left", V_P0);
    cntd = 1'b1;
    step(6'b000010, "score_right", V_P1);
    step(6'b001010, "score_add_p1", V_P1);
    step(6'b101010, "score_add_p0", V_P0);
    step(6'b000001, "score_ball_pf", V_PF);
    score_bar = 1'b1; cntd = 1'b0;

    // Write and read BK at the same edge: old value first, new value after.
    set_en(6'b000000);
    wr(4'b1000, V_BK2);
    #0;
    check("write_same_edge_old", V_BK, 1'b1);
    step(6'b000000, "write_new_visible", V_BK2);

    blank = 1'b1;
    set_en(6'b111111);
    tick();
    check("blank_all", 7'd0, 1'b0);
    blank = 1'b0;
    step(6'b100000, "unblank_p0", V_P0);

    // Mid-cycle asynchronous reset; strobes held during reset must not load.
    #3;
    reset_bar = 1'b0;
    #1;
    check("async_reset_clear", 7'd0, 1'b0);
    set_bus(V_PF);
    {bkci, pfci, p1ci, p0ci} = 4'b1111;
    tick();
    tick();
    {bkci, pfci, p1ci, p0ci} = 4'b0000;
    #3;
    reset_bar = 1'b1;
    step(6'b000000, "post_reset_bk", 7'd0);
    step(6'b100000, "post_reset_p0", 7'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
